// File: rtl/icache_pf_pkg.sv
// Shared types and address helpers for the icache next-line AXI prefetcher.
package icache_pf_pkg;

  localparam int unsigned AXI_ADDR_W = 64;
  localparam int unsigned AXI_DATA_W = 64;
  localparam int unsigned AXI_ID_W   = 4;

  typedef enum logic [2:0] {IDLE, FWD, PF_AR, PF_R, HIT} pf_state_e;

  typedef struct packed {
    logic [AXI_ID_W-1:0]   id;
    logic [AXI_ADDR_W-1:0] addr;
    logic [7:0]            len;
    logic [2:0]            size;
    logic [1:0]            burst;
    logic [3:0]            cache;
    logic [2:0]            prot;
  } ax_chan_t;

  typedef struct packed {
    logic [AXI_DATA_W-1:0]   data;
    logic [AXI_DATA_W/8-1:0] strb;
    logic                    last;
  } w_chan_t;

  typedef struct packed {
    logic [AXI_ID_W-1:0] id;
    logic [1:0]          resp;
  } b_chan_t;

  typedef struct packed {
    logic [AXI_ID_W-1:0]   id;
    logic [AXI_DATA_W-1:0] data;
    logic [1:0]            resp;
    logic                  last;
  } r_chan_t;

  typedef struct packed {
    ax_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ax_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } axi_req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    logic    b_valid;
    b_chan_t b;
    logic    r_valid;
    r_chan_t r;
  } axi_rsp_t;

  function automatic logic [AXI_ADDR_W-1:0] line_addr(input logic [AXI_ADDR_W-1:0] addr,
                                                      input int unsigned line_bytes);
    logic [AXI_ADDR_W-1:0] mask;
    mask = AXI_ADDR_W'(line_bytes - 1);
    return addr & ~mask;
  endfunction

  // True when the line after addr still lies in the same page as addr.
  function automatic logic next_line_in_page(input logic [AXI_ADDR_W-1:0] addr,
                                             input int unsigned line_bytes,
                                             input int unsigned page_bytes);
    logic [AXI_ADDR_W-1:0] pmask;
    logic [AXI_ADDR_W-1:0] nxt;
    pmask = AXI_ADDR_W'(page_bytes - 1);
    nxt   = line_addr(addr, line_bytes) + AXI_ADDR_W'(line_bytes);
    return (nxt & ~pmask) == (addr & ~pmask);
  endfunction

endpackage

// File: rtl/icache_pf_linebuf.sv
// One-line prefetch buffer: beat storage, tag/valid, and independent write/replay beat counters.
module icache_pf_linebuf #(
  parameter int unsigned DataW = 64,
  parameter int unsigned Beats = 2,
  parameter int unsigned TagW  = 60
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wr_en,
  input  logic             wr_last,
  input  logic [DataW-1:0] wr_dat,
  input  logic             rd_en,
  output logic [DataW-1:0] rd_dat,
  output logic             rd_last,
  input  logic             set_vld,
  input  logic [TagW-1:0]  set_tag,
  input  logic             clr_vld,
  output logic             vld,
  output logic [TagW-1:0]  tag
);

  localparam int unsigned CntW = (Beats > 1) ? $clog2(Beats) : 1;

  logic [DataW-1:0] mem_q [Beats];
  logic [CntW-1:0]  wr_cnt;
  logic [CntW-1:0]  rd_cnt;

  assign rd_dat  = mem_q[rd_cnt];
  assign rd_last = (rd_cnt == CntW'(Beats - 1));

  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_cnt] <= wr_dat;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_cnt <= '0;
      rd_cnt <= '0;
      vld    <= 1'b0;
      tag    <= '0;
    end else begin
      if (wr_en) wr_cnt <= wr_last ? '0 : wr_cnt + 1'b1;
      if (rd_en) rd_cnt <= rd_last ? '0 : rd_cnt + 1'b1;
      if (clr_vld) begin
        vld <= 1'b0;
      end else if (set_vld) begin
        vld <= 1'b1;
        tag <= set_tag;
      end
    end
  end

endmodule

// File: rtl/cva6_icache_axi_prefetcher.sv
// Next-line prefetcher on the icache AXI refill port; AW/W/B pass straight through.
// Optional ICACHE_PF_STATS_EN drives the pf_hit_o / pf_issue_o event pulses.
module cva6_icache_axi_prefetcher import icache_pf_pkg::*; #(
  parameter int unsigned AxiAddrWidth = 64,
  parameter int unsigned AxiDataWidth = 64,
  parameter int unsigned AxiIdWidth   = 4,
  parameter int unsigned LineWidth    = 128,
  parameter int unsigned PfId         = 1,
  parameter int unsigned PageBytes    = 4096,
  parameter type axi_req_t = icache_pf_pkg::axi_req_t,
  parameter type axi_rsp_t = icache_pf_pkg::axi_rsp_t
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  logic     flush_i,
  input  logic     en_i,
  input  axi_req_t slv_req_i,
  output axi_rsp_t slv_rsp_o,
  output axi_req_t mst_req_o,
  input  axi_rsp_t mst_rsp_i,
  output logic     pf_hit_o,
  output logic     pf_issue_o
);

  localparam int unsigned LineBeats = LineWidth / AxiDataWidth;
  localparam int unsigned LineBytes = LineWidth / 8;
  localparam int unsigned OffW      = $clog2(LineBytes);
  localparam int unsigned TagW      = AxiAddrWidth - OffW;
  localparam logic [7:0]  LineLen   = 8'(LineBeats - 1);
  localparam logic [2:0]  BeatSize  = 3'($clog2(AxiDataWidth / 8));

  pf_state_e state_q, state_d;
  logic [AxiAddrWidth-1:0] dem_line_q;
  logic                    dem_fill_q;
  logic [AxiIdWidth-1:0]   id_q;
  logic                    pf_bad_q;

  logic                    line_fill, buf_hit, ar_hs, launch_pf;
  logic                    buf_vld, buf_rd_last, buf_wr, buf_rd, buf_set, buf_clr;
  logic [TagW-1:0]         buf_tag;
  logic [AxiDataWidth-1:0] buf_dat;

  assign line_fill = (slv_req_i.ar.len == LineLen) && (slv_req_i.ar.addr[OffW-1:0] == '0);
  // A flush in the lookup cycle forces a miss.
  assign buf_hit   = line_fill && buf_vld && en_i && !flush_i &&
                     (buf_tag == slv_req_i.ar.addr[AxiAddrWidth-1:OffW]);
  assign ar_hs     = (state_q == IDLE) && slv_req_i.ar_valid && slv_rsp_o.ar_ready;
  assign launch_pf = dem_fill_q && en_i && !flush_i &&
                     next_line_in_page(dem_line_q, LineBytes, PageBytes);

  always_comb begin
    state_d            = state_q;
    mst_req_o          = slv_req_i;
    mst_req_o.ar_valid = 1'b0;
    mst_req_o.r_ready  = 1'b0;
    slv_rsp_o          = mst_rsp_i;
    slv_rsp_o.ar_ready = 1'b0;
    slv_rsp_o.r_valid  = 1'b0;
    slv_rsp_o.r        = '0;
    buf_wr             = 1'b0;
    buf_rd             = 1'b0;
    buf_set            = 1'b0;
    buf_clr            = flush_i;
    case (state_q)
      IDLE: begin
        if (buf_hit) begin
          slv_rsp_o.ar_ready = 1'b1;
          if (slv_req_i.ar_valid) state_d = HIT;
        end else begin
          mst_req_o.ar_valid = slv_req_i.ar_valid;
          slv_rsp_o.ar_ready = mst_rsp_i.ar_ready;
          if (slv_req_i.ar_valid && mst_rsp_i.ar_ready) state_d = FWD;
        end
      end
      FWD: begin
        mst_req_o.r_ready = slv_req_i.r_ready;
        slv_rsp_o.r_valid = mst_rsp_i.r_valid;
        slv_rsp_o.r       = mst_rsp_i.r;
        if (mst_rsp_i.r_valid && slv_req_i.r_ready && mst_rsp_i.r.last)
          state_d = launch_pf ? PF_AR : IDLE;
      end
      PF_AR: begin
        mst_req_o.ar_valid = 1'b1;
        mst_req_o.ar       = '0;
        mst_req_o.ar.id    = AxiIdWidth'(PfId);
        mst_req_o.ar.addr  = dem_line_q + AxiAddrWidth'(LineBytes);
        mst_req_o.ar.len   = LineLen;
        mst_req_o.ar.size  = BeatSize;
        mst_req_o.ar.burst = 2'b01;
        if (mst_rsp_i.ar_ready) state_d = PF_R;
      end
      PF_R: begin
        mst_req_o.r_ready = 1'b1;
        if (mst_rsp_i.r_valid) begin
          buf_wr = 1'b1;
          if (mst_rsp_i.r.last) begin
            buf_set = !(pf_bad_q || (mst_rsp_i.r.resp != 2'b00) || flush_i);
            state_d = IDLE;
          end
        end
      end
      HIT: begin
        slv_rsp_o.r_valid = 1'b1;
        slv_rsp_o.r.id    = id_q;
        slv_rsp_o.r.data  = buf_dat;
        slv_rsp_o.r.resp  = 2'b00;
        slv_rsp_o.r.last  = buf_rd_last;
        if (slv_req_i.r_ready) begin
          buf_rd = 1'b1;
          if (buf_rd_last) begin
            buf_clr = 1'b1;
            state_d = launch_pf ? PF_AR : IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      dem_line_q <= '0;
      dem_fill_q <= 1'b0;
      id_q       <= '0;
      pf_bad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (ar_hs) begin
        dem_line_q <= line_addr(slv_req_i.ar.addr, LineBytes);
        dem_fill_q <= line_fill;
        id_q       <= slv_req_i.ar.id;
      end
      if (state_q != PF_AR && state_d == PF_AR)
        pf_bad_q <= 1'b0;
      else if ((flush_i && (state_q == PF_AR || state_q == PF_R)) ||
               (buf_wr && mst_rsp_i.r.resp != 2'b00))
        pf_bad_q <= 1'b1;
    end
  end

  icache_pf_linebuf #(
    .DataW (AxiDataWidth),
    .Beats (LineBeats),
    .TagW  (TagW)
  ) i_linebuf (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .wr_en   (buf_wr),
    .wr_last (mst_rsp_i.r.last),
    .wr_dat  (mst_rsp_i.r.data),
    .rd_en   (buf_rd),
    .rd_dat  (buf_dat),
    .rd_last (buf_rd_last),
    .set_vld (buf_set),
    .set_tag (TagW'(((dem_line_q + AxiAddrWidth'(LineBytes)) >> OffW))),
    .clr_vld (buf_clr),
    .vld     (buf_vld),
    .tag     (buf_tag)
  );

`ifdef ICACHE_PF_STATS_EN
  assign pf_hit_o   = (state_q == IDLE) && buf_hit && slv_req_i.ar_valid;
  assign pf_issue_o = (state_q == PF_AR) && mst_rsp_i.ar_ready;
`else
  assign pf_hit_o   = 1'b0;
  assign pf_issue_o = 1'b0;
`endif

endmodule

// File: tb/tb_cva6_icache_axi_prefetcher.sv
// Randomized bench: icache-side reader, interconnect memory model, and a line-level buffer model.
module tb_cva6_icache_axi_prefetcher;
  import icache_pf_pkg::*;

  localparam logic [3:0] PF_ID = 4'd1;

  logic     clk = 1'b0;
  logic     rst_n = 1'b0;
  logic     flush = 1'b0;
  logic     en = 1'b0;
  axi_req_t slv_req, mst_req;
  axi_rsp_t slv_rsp, mst_rsp;
  logic     pf_hit, pf_issue;

  always #5 clk = ~clk;

  cva6_icache_axi_prefetcher dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .flush_i    (flush),
    .en_i       (en),
    .slv_req_i  (slv_req),
    .slv_rsp_o  (slv_rsp),
    .mst_req_o  (mst_req),
    .mst_rsp_i  (mst_rsp),
    .pf_hit_o   (pf_hit),
    .pf_issue_o (pf_issue)
  );

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] mem_word(input logic [63:0] a);
    return {a[31:0] ^ 32'hA5A5_0000, ~a[31:0]};
  endfunction

  typedef struct {
    logic [63:0] addr;
    logic [7:0]  len;
    logic [3:0]  id;
  } ar_exp_t;

  ar_exp_t     exp_ar_q[$];
  bit          m_vld = 1'b0;
  logic [63:0] m_line = '0;
  int          exp_hits = 0, exp_issues = 0, exp_beats = 0;
  int          hits_seen = 0, issues_seen = 0, beats_seen = 0;
  bit          err_arm = 1'b0;
  bit          pf_ar_seen = 1'b0;
  bit          b_inject = 1'b0;

  // Interconnect memory model: one burst at a time, random AR and R gaps.
  initial begin : slave
    bit          act;
    logic [63:0] b_addr;
    logic [7:0]  b_len, b_beat;
    logic [3:0]  b_id;
    bit          b_err;
    int          ar_wait, r_gap;
    ar_exp_t     e;
    act = 0; ar_wait = 0; r_gap = 0; b_addr = '0; b_len = '0; b_beat = '0; b_id = '0; b_err = 0;
    mst_rsp = '0;
    @(posedge rst_n);
    forever begin
      @(negedge clk);
      mst_rsp.ar_ready = !act && ar_wait == 0;
      mst_rsp.r_valid  = act && r_gap == 0;
      mst_rsp.r        = '0;
      mst_rsp.b_valid  = b_inject;
      mst_rsp.b.id     = 4'h6;
      if (act) begin
        mst_rsp.r.id   = b_id;
        mst_rsp.r.data = mem_word(b_addr + 64'(b_beat) * 8);
        mst_rsp.r.last = (b_beat == b_len);
        mst_rsp.r.resp = (b_err && b_beat == 8'd1) ? 2'b10 : 2'b00;
      end
      #1;
      if (mst_rsp.r_valid && mst_req.r_ready) begin
        if (b_beat == b_len) act = 0;
        else b_beat++;
        r_gap = $urandom_range(0, 2);
      end else if (act && r_gap > 0) begin
        r_gap--;
      end
      if (mst_req.ar_valid && mst_rsp.ar_ready) begin
        check("mst_ar_expected", exp_ar_q.size() != 0, 1);
        if (exp_ar_q.size() != 0) begin
          e = exp_ar_q.pop_front();
          check("mst_ar_addr", mst_req.ar.addr, e.addr);
          check("mst_ar_len", mst_req.ar.len, e.len);
          check("mst_ar_id", mst_req.ar.id, e.id);
          check("mst_ar_size", mst_req.ar.size, 3'd3);
          check("mst_ar_burst", mst_req.ar.burst, 2'b01);
        end
        act = 1; b_addr = mst_req.ar.addr; b_len = mst_req.ar.len; b_id = mst_req.ar.id; b_beat = 0;
        b_err = err_arm && mst_req.ar.id == PF_ID;
        if (b_err) err_arm = 0;
        if (mst_req.ar.id == PF_ID) pf_ar_seen = 1;
        ar_wait = $urandom_range(0, 2);
        r_gap   = $urandom_range(0, 2);
      end else if (mst_req.ar_valid && ar_wait > 0) begin
        ar_wait--;
      end
    end
  end

  initial begin : monitor
    forever begin
      @(negedge clk);
      #2;
      if (rst_n) begin
        if (slv_rsp.r_valid && slv_req.r_ready) beats_seen++;
        if (pf_hit) hits_seen++;
        if (pf_issue) issues_seen++;
      end
    end
  end

  task automatic do_read(input logic [63:0] addr, input logic [7:0] len, input logic [3:0] id,
                         input bit fl_ar, input bit fl_pf, input bit err);
    bit          fill, hit, pf, done;
    logic [63:0] line;
    ar_exp_t     e;
    int          k, cyc;
    line = {addr[63:4], 4'h0};
    fill = (len == 8'd1) && (addr[3:0] == 4'h0);
    hit  = fill && m_vld && (m_line == line) && en && !fl_ar;
    pf   = fill && en && (((line & 64'hFFF) + 64'd16) < 64'd4096);
    if (fl_ar) m_vld = 0;
    if (hit) begin
      m_vld = 0;
      exp_hits++;
    end else begin
      e.addr = addr; e.len = len; e.id = id;
      exp_ar_q.push_back(e);
    end
    if (pf) begin
      e.addr = line + 64'd16; e.len = 8'd1; e.id = PF_ID;
      exp_ar_q.push_back(e);
      exp_issues++;
    end
    err_arm    = err && pf;
    pf_ar_seen = 0;
    exp_beats += int'(len) + 1;

    @(negedge clk);
    slv_req.ar       = '0;
    slv_req.ar.addr  = addr;
    slv_req.ar.len   = len;
    slv_req.ar.id    = id;
    slv_req.ar.size  = 3'd3;
    slv_req.ar.burst = 2'b01;
    slv_req.ar_valid = 1'b1;
    flush = fl_ar;
    done = 0;
    for (int i = 0; i < 50 && !done; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      done = slv_rsp.ar_ready;
    end
    check("slv_ar_accept", done, 1);

    k = 0; cyc = 0;
    while (k <= int'(len) && cyc < 200) begin
      @(negedge clk);
      slv_req.ar_valid = 1'b0;
      flush = 1'b0;
      slv_req.r_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (slv_rsp.r_valid && slv_req.r_ready) begin
        check("slv_r_data", slv_rsp.r.data, mem_word(addr + 64'(k) * 8));
        check("slv_r_id", slv_rsp.r.id, id);
        check("slv_r_last", slv_rsp.r.last, k == int'(len));
        check("slv_r_resp", slv_rsp.r.resp, 2'b00);
        k++;
      end
      cyc++;
    end
    check("slv_r_beats", k, int'(len) + 1);
    @(negedge clk);
    slv_req.r_ready = 1'b1;

    if (fl_pf && pf) begin
      done = 0;
      for (int i = 0; i < 40 && !done; i++) begin
        @(negedge clk);
        #2;
        done = pf_ar_seen;
      end
      check("pf_ar_for_flush", done, 1);
      @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
    end
    if (pf) begin
      m_vld  = !err && !fl_pf;
      m_line = line + 64'd16;
    end

    repeat (30) @(negedge clk);
    #2;
    check("mst_ar_left", exp_ar_q.size(), 0);
    check("slv_r_total", beats_seen, exp_beats);
`ifdef ICACHE_PF_STATS_EN
    check("pf_hit_cnt", hits_seen, exp_hits);
    check("pf_issue_cnt", issues_seen, exp_issues);
`else
    check("pf_hit_cnt", hits_seen, 0);
    check("pf_issue_cnt", issues_seen, 0);
`endif
  endtask

  initial begin : main
    logic [63:0] a;
    logic [7:0]  l;
    logic [3:0]  ids [3];
    ids[0] = 4'd0; ids[1] = 4'd2; ids[2] = 4'd5;
    slv_req = '0;
    #12;
    check("rst_slv_arready", slv_rsp.ar_ready, 0);
    check("rst_slv_rvalid", slv_rsp.r_valid, 0);
    check("rst_mst_arvalid", mst_req.ar_valid, 0);
    check("rst_mst_rready", mst_req.r_ready, 0);
    check("rst_pf_hit", pf_hit, 0);
    check("rst_pf_issue", pf_issue, 0);
    @(negedge clk);
    rst_n = 1'b1;
    en = 1'b1;
    slv_req.r_ready = 1'b1;
    repeat (2) @(negedge clk);

    do_read(64'h8000_0000, 8'd1, 4'd0, 0, 0, 0);
    do_read(64'h8000_0010, 8'd1, 4'd0, 0, 0, 0);
    do_read(64'h8000_0FF0, 8'd1, 4'd0, 0, 0, 0);
    do_read(64'h1000_0004, 8'd0, 4'd0, 0, 0, 0);
    do_read(64'h8000_0100, 8'd1, 4'd0, 0, 1, 0);
    do_read(64'h8000_0110, 8'd1, 4'd0, 0, 0, 0);
    do_read(64'h8000_0200, 8'd1, 4'd0, 0, 0, 1);
    do_read(64'h8000_0210, 8'd1, 4'd0, 0, 0, 0);
    do_read(64'h8000_0300, 8'd1, 4'd2, 0, 0, 0);
    do_read(64'h8000_0310, 8'd1, 4'd2, 1, 0, 0);
    do_read(64'h8000_0400, 8'd1, 4'd0, 0, 0, 0);
    en = 1'b0;
    do_read(64'h8000_0410, 8'd1, 4'd0, 0, 0, 0);
    en = 1'b1;

    @(negedge clk);
    slv_req.aw_valid = 1'b1;
    slv_req.aw.addr  = 64'h2000_1230;
    b_inject = 1'b1;
    @(negedge clk);
    #1;
    check("aw_pass_valid", mst_req.aw_valid, 1);
    check("aw_pass_addr", mst_req.aw.addr, 64'h2000_1230);
    check("b_pass_valid", slv_rsp.b_valid, 1);
    check("b_pass_id", slv_rsp.b.id, 4'h6);
    @(negedge clk);
    slv_req.aw_valid = 1'b0;
    b_inject = 1'b0;

    for (int n = 0; n < 150; n++) begin
      en = ($urandom_range(0, 7) != 0);
      if (m_vld && $urandom_range(0, 1) == 1)
        a = m_line;
      else if ($urandom_range(0, 3) == 0)
        a = 64'h8000_0FC0 + 64'(16 * $urandom_range(0, 3));
      else
        a = 64'h8000_0000 + 64'(16 * $urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0) a = a + 64'd8;
      l = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'd1;
      do_read(a, l, ids[$urandom_range(0, 2)],
              $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
